serial_rx: RTL and testbench
============================

# serial_rx

Memory-mapped UART receiver, the input counterpart of the serial output device. Deserializes 8N1 frames from the `rx` pin into a FIFO that the CPU drains through MMIO loads. It sits on the memory ring as a peripheral, with its own bounds-check server at `SERIAL_RX_MEM_BASE`/`SERIAL_RX_MEM_SIZE` (from `defines.sv`).

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Even, ≥4.
- `FIFO_DEPTH`, default 8: receive FIFO entries. Power of two, ≥2.
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `mem_in_port`, `mem_if.bus`, –: CPU load/store port (`addr`, `read_en`, `write_en`, `data_i`, `data_o`, `hit`, `done`).
- `bounds_checker`, `mem_bounds.server`, –: `in_bounds` = `check_addr` in [`SERIAL_RX_MEM_BASE`, `SERIAL_RX_MEM_BASE + SERIAL_RX_MEM_SIZE`). Combinational.
- `rx`, input, 1: asynchronous serial line, idle high.

## Operation
- **Register map:**
  - Offset 0x0, DATA (read): `[7:0]` byte, `[8]` valid, rest 0.
  - Offset 0x4, STATUS (read): `[0]` not-empty, `[1]` full, `[2]` overrun, `[3]` framing error, `[15:8]` count, rest 0.
  - Other in-window offsets read 0. Writes to them are ignored.
- **Memory port:**
  - `hit` is combinational: (`read_en` | `write_en`) and `addr` in window.
  - `done` is `hit` registered one cycle later.
  - `data_o` is registered on the hit cycle and valid in the `done` cycle.
- **Side effects** apply only when `hit` && !`done`, so a strobe held until `done` acts once.
  - DATA read on a non-empty FIFO pops the head and returns valid=1.
  - DATA read on an empty FIFO returns 0x000 and leaves pointers unchanged.
  - STATUS write: `data_i[2]`=1 clears overrun; `data_i[3]`=1 clears framing error.
  - DATA writes are ignored but still hit.
- **rx sync:** 2-flop synchronizer, both flops reset to 1.
- **Receiver FSM states:** IDLE, START, DATA, STOP.
  - IDLE: a synchronized falling edge moves to START; the bit counter clears.
  - START: wait `CLKS_PER_BIT/2` cycles. If rx is still 0, go to DATA. If rx is 1, treat it as a glitch and return to IDLE with nothing pushed.
  - DATA: sample every `CLKS_PER_BIT` cycles, LSB first. After the 8th bit, go to STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles, then return to IDLE.
- **Push:** on the STOP sample, the byte is pushed (subject to Configuration).
  - Push while full: byte dropped, overrun set.
  - Push and pop in the same cycle: both occur, count unchanged. When full, a same-cycle pop frees the slot and no overrun is raised.
- **Sticky flags:** if set and clear happen in the same cycle, set wins.
- **Count arithmetic:** pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth. Count is `$clog2(FIFO_DEPTH)+1` bits, zero-extended into `[15:8]`.

## Timing
- **Reset (any state, including mid-frame):**
  - FSM returns to IDLE.
  - FIFO empties; count is 0.
  - Flags clear.
  - `data_o`=0 and `done`=0.
  - `hit` remains combinational.
- **Frame timing:** let t0 be the cycle the synchronized rx first reads 0 (2 cycles after the pin falls).
  - Sample k (k=0 start, 1..8 data, 9 stop) occurs at t0 + `CLKS_PER_BIT/2` + k·`CLKS_PER_BIT`.
  - The push registers at the end of the stop-sample cycle; STATUS not-empty is visible to a read hitting the following cycle.
- **Back-to-back frames:** the receiver is in IDLE from mid-stop-bit onward, so back-to-back frames with one stop bit are received without loss.
- **Read latency:** 1 cycle from `hit` to `done`/`data_o`.

## Configuration
- **`SERIAL_RX_FRAME_CHECK_EN` defined:** a stop bit sampled as 0 discards the byte, sets the framing error flag, and does not touch the FIFO.
- **`SERIAL_RX_FRAME_CHECK_EN` undefined:** the stop sample is ignored, every frame is pushed, and STATUS `[3]` reads constant 0 (writes to it have no effect).

## Test plan
- **Single byte:** reset, then drive frame 0x41 with `CLKS_PER_BIT`=16. STATUS reads 0x0000_0101 after the stop sample; a DATA read returns 0x141; STATUS then reads 0x0000_0000.
- **Overrun:** send 9 frames 0x00..0x08 into an 8-deep FIFO with no reads. STATUS = 0x0000_0807 (count 8, full, overrun, not-empty). Eight DATA reads return 0x100..0x107 in order. Writing 0x4 to STATUS clears overrun.
- **Framing error (macro defined):** frame 0x55 with stop bit 0. FIFO stays empty and STATUS = 0x0000_0008. Without the macro, STATUS = 0x0000_0101 and DATA returns 0x155.
- **Glitch and empty read:** a 3-cycle low pulse on rx pushes nothing. A DATA read on the empty FIFO returns 0x000, `done` asserts one cycle after `hit`, and count stays 0.
- **Held strobe and boundary:** with `read_en` held for 2 cycles on DATA, exactly one byte pops. Pushing and popping in the same cycle while full leaves count 8 with overrun clear. Asserting reset mid-DATA-state leaves STATUS=0 and the next full frame is received correctly.

Source files
------------

// File: rtl/serial_rx_if.sv
// Bus interfaces used by serial_rx.
//
// mem_if     : CPU load/store port. The peripheral side uses modport bus
//              (addr, read_en, write_en, data_i in; data_o, hit, done out).
//              The CPU side uses modport cpu.
// mem_bounds : address-window query. The peripheral answers through modport
//              server (check_addr in; in_bounds out, combinational).

interface mem_if;
  logic [31:0] addr;
  logic        read_en;
  logic        write_en;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        hit;
  logic        done;

  modport bus (input addr, read_en, write_en, data_i, output data_o, hit, done);
  modport cpu (output addr, read_en, write_en, data_i, input data_o, hit, done);
endinterface

interface mem_bounds;
  logic [31:0] check_addr;
  logic        in_bounds;

  modport server (input check_addr, output in_bounds);
  modport client (output check_addr, input in_bounds);
endinterface

// File: rtl/serial_rx.sv
// serial_rx - memory-mapped 8N1 UART receiver with a receive FIFO.
//
// Bytes arriving on rx are deserialized and pushed into a FIFO that the CPU
// drains by loading the DATA register.
//
// Parameters:
//   CLKS_PER_BIT : clocks per UART bit (even, >= 4)
//   FIFO_DEPTH   : receive FIFO entries (power of two, >= 2)
// Ports:
//   clk            : sole clock, rising edge
//   reset          : synchronous, active-high
//   mem_in_port    : CPU load/store port (mem_if.bus)
//   bounds_checker : window query for [SERIAL_RX_MEM_BASE, +SERIAL_RX_MEM_SIZE)
//   rx             : asynchronous serial line, idle high
// Register map (offset from SERIAL_RX_MEM_BASE):
//   0x0 DATA   (read)  : [7:0] byte, [8] valid; a read pops a non-empty FIFO
//   0x4 STATUS (read)  : [0] not-empty, [1] full, [2] overrun,
//                        [3] framing error, [15:8] count
//       STATUS (write) : data_i[2] clears overrun, data_i[3] clears framing
// Build option:
//   SERIAL_RX_FRAME_CHECK_EN : when defined, a frame whose stop bit samples 0
//   is discarded and raises the framing-error flag; otherwise every frame is
//   pushed and STATUS[3] is constant 0.

`ifndef SERIAL_RX_MEM_BASE
`define SERIAL_RX_MEM_BASE 32'h4000_1000
`endif
`ifndef SERIAL_RX_MEM_SIZE
`define SERIAL_RX_MEM_SIZE 32'h0000_0010
`endif

module serial_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic      clk,
  input  logic      reset,
  mem_if.bus        mem_in_port,
  mem_bounds.server bounds_checker,
  input  logic      rx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  localparam logic [31:0] BASE = `SERIAL_RX_MEM_BASE;
  localparam logic [31:0] SIZE = `SERIAL_RX_MEM_SIZE;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Unsigned offset compare: addresses below BASE wrap to huge offsets and
  // fall outside, and BASE+SIZE may reach 2^32 without overflow trouble.
  function automatic logic in_window(input logic [31:0] a);
    return (a - BASE) < SIZE;
  endfunction

  assign bounds_checker.in_bounds = in_window(bounds_checker.check_addr);

  // ---- stage p0/p1: rx synchronizer; p2 holds the previous synced value ----
  logic rx_p0, rx_p1, rx_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // ---- receiver FSM ----
  logic [1:0]    state_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          stop_smp;
  logic          data_smp;

  assign data_smp = (state_q == S_DATA) && (tick_q == BIT_LAST);
  assign stop_smp = (state_q == S_STOP) && (tick_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tick_q <= '0;
          if (rx_p2 && !rx_p1) begin
            state_q <= S_START;
            bit_q   <= '0;
          end
        end
        S_START: begin
          if (tick_q == HALF_LAST) begin
            tick_q  <= '0;
            // A line back high at mid-start-bit was only a glitch.
            state_q <= rx_p1 ? S_IDLE : S_DATA;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == BIT_LAST) begin
            tick_q <= '0;
            bit_q  <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_STOP;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop-bit lets the next start edge be seen.
          if (tick_q == BIT_LAST) begin
            tick_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (data_smp) shift_q <= {rx_p1, shift_q[7:1]};
  end

  // ---- memory port decode ----
  logic [31:0] off;
  logic        hit;
  logic        done_q;
  logic        act;
  logic        sel_data;
  logic        sel_stat;
  logic        pop;
  logic        stat_wr;

  assign off      = mem_in_port.addr - BASE;
  assign hit      = (mem_in_port.read_en || mem_in_port.write_en) && in_window(mem_in_port.addr);
  // A strobe held into its done cycle must not act a second time.
  assign act      = hit && !done_q;
  assign sel_data = (off == 32'h0);
  assign sel_stat = (off == 32'h4);

  // ---- FIFO ----
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          empty, full;
  logic          push_req, push_ok;
  logic          ovr_q;
  logic          ferr;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop     = act && mem_in_port.read_en && sel_data && !empty;
  assign stat_wr = act && mem_in_port.write_en && sel_stat;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= shift_q;
  end

  // Sticky flags: a same-cycle set beats the CPU clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= (ovr_q && !(stat_wr && mem_in_port.data_i[2]))
               || (push_req && full && !pop);
    end
  end

  logic unused_data_i;

`ifdef SERIAL_RX_FRAME_CHECK_EN
  logic ferr_q;

  assign push_req = stop_smp && rx_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= (ferr_q && !(stat_wr && mem_in_port.data_i[3]))
                || (stop_smp && !rx_p1);
    end
  end

  assign ferr          = ferr_q;
  assign unused_data_i = ^{mem_in_port.data_i[31:4], mem_in_port.data_i[1:0]};
`else
  assign push_req      = stop_smp;
  assign ferr          = 1'b0;
  assign unused_data_i = ^{mem_in_port.data_i[31:3], mem_in_port.data_i[1:0]};
`endif

  // ---- read mux and registered response ----
  logic [31:0] rdata;
  logic [31:0] data_q;

  always_comb begin
    rdata = '0;
    if (sel_data && !empty) begin
      rdata = {23'd0, 1'b1, fifo_mem[rd_ptr_q]};
    end else if (sel_stat) begin
      rdata = {16'd0, 8'(count_q), 4'd0, ferr, ovr_q, full, !empty};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      done_q <= hit;
      if (act) data_q <= mem_in_port.read_en ? rdata : 32'd0;
    end
  end

  assign mem_in_port.hit    = hit;
  assign mem_in_port.done   = done_q;
  assign mem_in_port.data_o = data_q;

endmodule

// File: tb/tb_serial_rx.sv
// Testbench for serial_rx: drives 8N1 frames on rx and MMIO accesses on the
// memory port; received bytes are tracked in a scoreboard queue and compared
// against DATA reads.

`ifndef SERIAL_RX_MEM_BASE
`define SERIAL_RX_MEM_BASE 32'h4000_1000
`endif
`ifndef SERIAL_RX_MEM_SIZE
`define SERIAL_RX_MEM_SIZE 32'h0000_0010
`endif

module tb_serial_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE   = `SERIAL_RX_MEM_BASE;
  localparam logic [31:0] SIZE   = `SERIAL_RX_MEM_SIZE;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;

  mem_if     mif ();
  mem_bounds mb ();

  serial_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_in_port    (mif),
    .bounds_checker (mb),
    .rx             (rx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle_cycles(CPB);
    end
    rx = stop;
    idle_cycles(CPB);
    rx = 1'b1;
  endtask

  task automatic mmio_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                           output logic h, output logic done_hit, output logic done_after);
    mif.addr     = a;
    mif.data_i   = '0;
    mif.write_en = 1'b0;
    mif.read_en  = 1'b1;
    #1;
    h        = mif.hit;
    done_hit = mif.done;
    @(posedge clk);
    #1;
    d          = mif.data_o;
    done_after = mif.done;
    if (hold > 1) idle_cycles(hold - 1);
    mif.read_en = 1'b0;
    idle_cycles(1);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    logic h, dh, da;
    mmio_read(a, 1, d, h, dh, da);
  endtask

  task automatic mmio_write(input logic [31:0] a, input logic [31:0] v);
    mif.addr     = a;
    mif.data_i   = v;
    mif.read_en  = 1'b0;
    mif.write_en = 1'b1;
    @(posedge clk);
    #1;
    mif.write_en = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic h, dh, da;
    logic [31:0] baddr [4];
    logic        bexp  [4];
    reset = 1'b1;
    idle_cycles(3);
    checks++;
    if (mif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", mif.done); end
    checks++;
    if (mif.data_o !== 32'h0) begin errors++; $display("FAIL reset_data_o: got %h want 0", mif.data_o); end
    mif.addr = A_STAT; mif.read_en = 1'b1;
    #1;
    checks++;
    if (mif.hit !== 1'b1) begin errors++; $display("FAIL reset_hit_comb: got %b want 1", mif.hit); end
    mif.read_en = 1'b0;
    idle_cycles(1);
    reset = 1'b0;
    idle_cycles(2);
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 00000000", d); end
    baddr[0] = BASE - 32'h1;        bexp[0] = 1'b0;
    baddr[1] = BASE;                bexp[1] = 1'b1;
    baddr[2] = BASE + SIZE - 32'h1; bexp[2] = 1'b1;
    baddr[3] = BASE + SIZE;         bexp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mb.check_addr = baddr[i];
      #1;
      checks++;
      if (mb.in_bounds !== bexp[i]) begin
        errors++;
        $display("FAIL bounds_%0d: addr %h got %b want %b", i, baddr[i], mb.in_bounds, bexp[i]);
      end
    end
    mmio_read(BASE + SIZE, 1, d, h, dh, da);
    checks++;
    if (h !== 1'b0 || da !== 1'b0) begin
      errors++; $display("FAIL out_of_window: hit %b done %b want 0 0", h, da);
    end
    mmio_read(BASE + 32'h8, 1, d, h, dh, da);
    checks++;
    if (h !== 1'b1 || da !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL offset8_read: hit %b done %b data %h want 1 1 00000000", h, da, d);
    end
  endtask

  task automatic test_single_byte;
    logic [31:0] d, e;
    send_frame(8'h41, 1'b1);
    exp_q.push_back(8'h41);
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0101) begin errors++; $display("FAIL single_status: got %h want 00000101", d); end
    rd(A_DATA, d);
    e = (exp_q.size() > 0) ? {23'd0, 1'b1, exp_q.pop_front()} : 32'hDEAD_BEEF;
    checks++;
    if (d !== e) begin errors++; $display("FAIL single_data: got %h want %h", d, e); end
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL single_status_after: got %h want 00000000", d); end
  endtask

  task automatic test_overrun;
    logic [31:0] d, e;
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1);
      if (i < DEPTH) exp_q.push_back(8'(i));
    end
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0807) begin errors++; $display("FAIL overrun_status: got %h want 00000807", d); end
    for (int i = 0; i < DEPTH; i++) begin
      rd(A_DATA, d);
      e = (exp_q.size() > 0) ? {23'd0, 1'b1, exp_q.pop_front()} : 32'hDEAD_BEEF;
      checks++;
      if (d !== e) begin errors++; $display("FAIL overrun_data_%0d: got %h want %h", i, d, e); end
    end
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0004) begin errors++; $display("FAIL overrun_drained: got %h want 00000004", d); end
    mmio_write(A_STAT, 32'h4);
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL overrun_clear: got %h want 00000000", d); end
  endtask

  task automatic test_framing;
    logic [31:0] d, e;
    send_frame(8'h55, 1'b0);
    idle_cycles(CPB);
`ifdef SERIAL_RX_FRAME_CHECK_EN
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0008) begin errors++; $display("FAIL framing_status: got %h want 00000008", d); end
    rd(A_DATA, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL framing_data: got %h want 00000000", d); end
`else
    exp_q.push_back(8'h55);
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0101) begin errors++; $display("FAIL framing_status: got %h want 00000101", d); end
    rd(A_DATA, d);
    e = (exp_q.size() > 0) ? {23'd0, 1'b1, exp_q.pop_front()} : 32'hDEAD_BEEF;
    checks++;
    if (d !== e) begin errors++; $display("FAIL framing_data: got %h want %h", d, e); end
`endif
    mmio_write(A_STAT, 32'h8);
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL framing_clear: got %h want 00000000", d); end
  endtask

  task automatic test_glitch_empty;
    logic [31:0] d;
    logic h, dh, da;
    rx = 1'b0;
    idle_cycles(3);
    rx = 1'b1;
    idle_cycles(3 * CPB);
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_status: got %h want 00000000", d); end
    mmio_read(A_DATA, 1, d, h, dh, da);
    checks++;
    if (h !== 1'b1 || dh !== 1'b0 || da !== 1'b1) begin
      errors++; $display("FAIL empty_handshake: hit %b done_now %b done_next %b want 1 0 1", h, dh, da);
    end
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL empty_data: got %h want 00000000", d); end
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL empty_status: got %h want 00000000", d); end
  endtask

  task automatic test_held_strobe;
    logic [31:0] d, e;
    logic h, dh, da;
    send_frame(8'h3C, 1'b1); exp_q.push_back(8'h3C);
    send_frame(8'hC3, 1'b1); exp_q.push_back(8'hC3);
    mmio_read(A_DATA, 2, d, h, dh, da);
    e = (exp_q.size() > 0) ? {23'd0, 1'b1, exp_q.pop_front()} : 32'hDEAD_BEEF;
    checks++;
    if (d !== e) begin errors++; $display("FAIL held_data: got %h want %h", d, e); end
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0101) begin errors++; $display("FAIL held_status: got %h want 00000101", d); end
    rd(A_DATA, d);
    e = (exp_q.size() > 0) ? {23'd0, 1'b1, exp_q.pop_front()} : 32'hDEAD_BEEF;
    checks++;
    if (d !== e) begin errors++; $display("FAIL held_second: got %h want %h", d, e); end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] d, e, d_pop, e_pop;
    logic h, dh, da;
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1);
      exp_q.push_back(8'h10 + 8'(i));
    end
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0803) begin errors++; $display("FAIL full_status: got %h want 00000803", d); end
    // Pin falls now; the stop sample lands 154 edges later, and the read
    // is placed to hit in exactly that cycle.
    fork
      send_frame(8'hAA, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        mmio_read(A_DATA, 1, d_pop, h, dh, da);
      end
    join
    e_pop = (exp_q.size() > 0) ? {23'd0, 1'b1, exp_q.pop_front()} : 32'hDEAD_BEEF;
    exp_q.push_back(8'hAA);
    checks++;
    if (d_pop !== e_pop) begin errors++; $display("FAIL pushpop_data: got %h want %h", d_pop, e_pop); end
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0803) begin errors++; $display("FAIL pushpop_status: got %h want 00000803", d); end
    for (int i = 0; i < DEPTH; i++) begin
      rd(A_DATA, d);
      e = (exp_q.size() > 0) ? {23'd0, 1'b1, exp_q.pop_front()} : 32'hDEAD_BEEF;
      checks++;
      if (d !== e) begin errors++; $display("FAIL pushpop_drain_%0d: got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d, e;
    send_frame(8'h99, 1'b1);
    rx = 1'b0;
    idle_cycles(3 * CPB);
    reset = 1'b1;
    idle_cycles(2);
    exp_q.delete();
    rx = 1'b1;
    reset = 1'b0;
    idle_cycles(2 * CPB);
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h want 00000000", d); end
    send_frame(8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    rd(A_STAT, d);
    checks++;
    if (d !== 32'h0000_0101) begin errors++; $display("FAIL midreset_next_status: got %h want 00000101", d); end
    rd(A_DATA, d);
    e = (exp_q.size() > 0) ? {23'd0, 1'b1, exp_q.pop_front()} : 32'hDEAD_BEEF;
    checks++;
    if (d !== e) begin errors++; $display("FAIL midreset_next_data: got %h want %h", d, e); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mif.addr      = '0;
    mif.data_i    = '0;
    mif.read_en   = 1'b0;
    mif.write_en  = 1'b0;
    mb.check_addr = '0;
    @(posedge clk);
    #1;
    test_reset;
    test_single_byte;
    test_overrun;
    test_framing;
    test_glitch_empty;
    test_held_strobe;
    test_full_push_pop;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
